// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: turns one-cycle game-event pulses into timed note-code
// melodies for the piezo tone generator, with priority preemption and muting.
module sfx_sequencer #(
  parameter int TICK_DIV = 1000,
  parameter int NOTE_MS  = 150,
  parameter int GAP_MS   = 20
) (
  input  logic       clk_1MHz,
  input  logic       rst,
  input  logic       mute,
  input  logic       trig_hit,
  input  logic       trig_miss,
  input  logic       trig_start,
  input  logic       trig_over,
  output logic [3:0] mode,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;
  // Encoding doubles as priority: a larger value preempts a smaller one.
  typedef enum logic [1:0] {MEL_HIT, MEL_MISS, MEL_START, MEL_OVER} mel_t;

  localparam logic [15:0] PRE_MAX   = 16'(TICK_DIV - 1);
  localparam logic [7:0]  NOTE_LAST = 8'(NOTE_MS - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_MS - 1);

  function automatic logic [3:0] rom_note(input mel_t m, input logic [1:0] i);
    logic [3:0] n;
    n = 4'd0;
    case (m)
      MEL_HIT:   n = i[0] ? 4'd8 : 4'd5;
      MEL_MISS:  n = i[0] ? 4'd1 : 4'd3;
      MEL_START:
        case (i)
          2'd0:    n = 4'd1;
          2'd1:    n = 4'd3;
          2'd2:    n = 4'd5;
          default: n = 4'd8;
        endcase
      default:
        case (i)
          2'd0:    n = 4'd8;
          2'd1:    n = 4'd5;
          2'd2:    n = 4'd3;
          default: n = 4'd1;
        endcase
    endcase
    return n;
  endfunction

  state_t      state_q, state_n;
  mel_t        mel_q, mel_n, trig_mel;
  logic [1:0]  idx_q, idx_n, last_idx;
  logic [15:0] pre_q, pre_n;
  logic [7:0]  ms_q, ms_n;
  logic [3:0]  mode_q, mode_n;
  logic        done_q, done_n;
  logic        any_trig, tick, note_end, gap_end, final_end, accept;

  always_ff @(posedge clk_1MHz) begin
    if (!rst) begin
      state_q <= IDLE;
      mel_q   <= MEL_HIT;
      idx_q   <= 2'd0;
      pre_q   <= 16'd0;
      ms_q    <= 8'd0;
      mode_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      mel_q   <= mel_n;
      idx_q   <= idx_n;
      pre_q   <= pre_n;
      ms_q    <= ms_n;
      mode_q  <= mode_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    any_trig = trig_hit | trig_miss | trig_start | trig_over;
    if (trig_over)       trig_mel = MEL_OVER;
    else if (trig_start) trig_mel = MEL_START;
    else if (trig_miss)  trig_mel = MEL_MISS;
    else                 trig_mel = MEL_HIT;

    tick      = (pre_q == PRE_MAX);
    note_end  = (state_q == NOTE) && tick && (ms_q == NOTE_LAST);
    gap_end   = (state_q == GAP) && tick && (ms_q == GAP_LAST);
    last_idx  = (mel_q == MEL_HIT || mel_q == MEL_MISS) ? 2'd1 : 2'd3;
    final_end = gap_end && (idx_q == last_idx);
    // A trigger landing on the final gap expiry wins regardless of priority.
    accept    = any_trig && ((state_q == IDLE) || (trig_mel >= mel_q) || final_end);

    state_n = state_q;
    mel_n   = mel_q;
    idx_n   = idx_q;
    pre_n   = pre_q;
    ms_n    = ms_q;
    done_n  = 1'b0;

    if (accept) begin
      state_n = NOTE;
      mel_n   = trig_mel;
      idx_n   = 2'd0;
      pre_n   = 16'd0;
      ms_n    = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          pre_n = 16'd0;
          ms_n  = 8'd0;
        end
        NOTE, GAP: begin
          if (note_end) begin
            state_n = GAP;
            pre_n   = 16'd0;
            ms_n    = 8'd0;
          end else if (gap_end) begin
            pre_n = 16'd0;
            ms_n  = 8'd0;
            if (final_end) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = NOTE;
              idx_n   = idx_q + 2'd1;
            end
          end else if (tick) begin
            pre_n = 16'd0;
            ms_n  = ms_q + 8'd1;
          end else begin
            pre_n = pre_q + 16'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    mode_n = (state_n == NOTE && !mute) ? rom_note(mel_n, idx_n) : 4'd0;
  end

  assign mode = mode_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
